// File: rtl/mazesolver_soc_pio_pkg.sv
// Shared constants for the output PIO: register word addresses and PWM duty width.
package mazesolver_soc_pio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DUTY_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PHASE    = 3'd5;

endpackage

// File: rtl/mazesolver_soc_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO (zero wait state, no read strobe).
interface mazesolver_soc_pio_out_if;
    import mazesolver_soc_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/mazesolver_soc_pwm_timebase.sv
// Prescaled PWM timebase: a free-running prescaler produces a one-cycle tick
// every PRESCALE clocks, and an 8-bit phase counter advances on each tick.
module mazesolver_soc_pwm_timebase
    import mazesolver_soc_pio_pkg::*;
#(
    parameter int unsigned PRESCALE = 500
) (
    input  logic              clk,
    input  logic              reset,
    output logic              tick,
    output logic [DUTY_W-1:0] phase
);

    // PRESCALE = 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int unsigned      CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DUTY_W-1:0] phase_q, phase_d;

    assign tick  = (cnt_q == LAST);
    assign phase = phase_q;

    // Prescaler wraps on tick; phase wraps naturally from 255 to 0.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (tick) begin
            cnt_d   = '0;
            phase_d = phase_q + 1'b1;
        end
    end

    // Timebase state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mazesolver_soc_pio_out.sv
// Parametrised Avalon-MM output PIO with atomic set/clear and per-bit PWM dimming.
module mazesolver_soc_pio_out
    import mazesolver_soc_pio_pkg::*;
#(
    parameter int unsigned          WIDTH       = 8,
    parameter int unsigned          PRESCALE    = 500,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    mazesolver_soc_pio_out_if.slave bus,
    output logic [WIDTH-1:0]        out_port
);

    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  mode_q, mode_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [WIDTH-1:0]  out_q, out_d;

    logic              wr_en;
    logic [WIDTH-1:0]  wr_bits;
    logic              tick;
    logic [DUTY_W-1:0] phase;
    logic              pwm_on;

    mazesolver_soc_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .phase (phase)
    );

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign wr_bits = bus.writedata[WIDTH-1:0];

    // Register file next state; only one address is written per cycle.
    always_comb begin
        data_d = data_q;
        mode_d = mode_q;
        duty_d = duty_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = wr_bits;
                ADDR_OUTSET:   data_d = data_q | wr_bits;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_bits;
                ADDR_MODE:     mode_d = wr_bits;
                ADDR_DUTY:     duty_d = bus.writedata[DUTY_W-1:0];
                default:       ;
            endcase
        end
    end

    // A PWM bit is gated by the compare; a static bit passes DATA straight through.
    always_comb begin
        pwm_on = (phase < duty_q);
        out_d  = data_q & (~mode_q | {WIDTH{pwm_on}});
    end

    // Registers and pin outputs; reset discards any concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mode_q <= '0;
            duty_q <= '0;
            out_q  <= RESET_VALUE;
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign out_port = out_q;

    // Zero-latency read mux; write-only and unmapped words read as zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:  bus.readdata = 32'(data_q);
            ADDR_MODE:  bus.readdata = 32'(mode_q);
            ADDR_DUTY:  bus.readdata = 32'(duty_q);
            ADDR_PHASE: bus.readdata = 32'(phase);
            default:    bus.readdata = '0;
        endcase
    end

endmodule

// File: doc/mazesolver_soc_pio_out.md
# mazesolver_soc_pio_out

Parametrised Avalon-MM output PIO for board indicators (LEDs, buzzers), next generation of the fixed 8-bit LED port. It adds configurable width, atomic bit set/clear registers and a per-bit PWM brightness mode driven by an internal prescaled timebase. It sits on the Nios II data master as a zero-wait-state slave and drives `out_port` straight to top-level pins.

## Interface
Parameters:
- `WIDTH`, 8: output bits, legal 1..32.
- `PRESCALE`, 500: clk cycles per PWM phase step, legal ≥ 1.
- `RESET_VALUE`, 0: value of DATA and `out_port` after reset (WIDTH bits).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  register word index.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read data, zero-extended.
- `out_port`  out  WIDTH  registered pin outputs.

## Operation
- Write occurs when `chipselect && !write_n`; one register per cycle, so no intra-block write conflicts.
- Register map (word address):
  - 0 DATA, rw: `data <= writedata[WIDTH-1:0]`.
  - 1 OUTSET, wo: `data <= data | writedata[WIDTH-1:0]`; reads 0.
  - 2 OUTCLEAR, wo: `data <= data & ~writedata[WIDTH-1:0]`; reads 0.
  - 3 MODE, rw: per bit, 0 = static, 1 = PWM.
  - 4 DUTY, rw: 8-bit global duty `duty[7:0]`; bits 31:8 read 0.
  - 5 PHASE, ro: current 8-bit phase counter, for test/debug.
  - 6, 7: read 0; writes ignored.
- Bits above WIDTH: writes ignored, reads 0.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; `tick` is asserted in the cycle it equals PRESCALE-1, then it wraps to 0.
  - 8-bit phase increments on `tick`, wrapping 255→0.
  - PRESCALE = 1 gives `tick` every cycle.
- `pwm_on = (phase < duty)`:
  - duty 0: always off.
  - duty 255: on 255 of 256 phases.
- Next output per bit i: `data[i] & (mode[i] ? pwm_on : 1'b1)`.
- A bit with DATA = 0 is always low, whatever its MODE.
- DUTY, MODE and DATA writes take effect at the next compare; the phase is not restarted.

## Timing
- Reset (synchronous, `reset` high at a clk edge):
  - DATA = RESET_VALUE; MODE = 0; DUTY = 0.
  - Prescaler = 0; phase = 0.
  - `out_port` = RESET_VALUE.
  - `readdata` follows the reset register contents in the same cycle.
- Reset mid-operation: all state above is forced on that edge; a concurrent write is discarded.
- Write on edge N:
  - Register updated at edge N.
  - `out_port` reflects it at edge N+1 (1-cycle latency).
  - A read at N+1 returns the new value.
- `readdata` is combinational from `address` and register state (zero read latency); `read_n` is not used.
- The phase step on `tick` at edge N affects `out_port` at edge N+1.
- PWM period = 256 × PRESCALE clk cycles.

## Structure
- Package `mazesolver_soc_pio_pkg`: register address constants (ADDR_DATA … ADDR_PHASE), duty width constant (8).
- Sub-module `mazesolver_soc_pwm_timebase` (params PRESCALE; ports clk, reset, tick, phase[7:0]).
- Top: register file, set/clear logic, compare and output register.

## Test plan
- Reset with RESET_VALUE = 8'hA5 → `out_port` = 8'hA5; reads of addresses 0/3/4 return 32'hA5/0/0.
- Write DATA = 8'h0F, then OUTSET 8'h30, then OUTCLEAR 8'h03 → `out_port` sequence 0F, 3F, 3C, each one cycle after its write; reads of addresses 1 and 2 return 0.
- PRESCALE = 2, MODE = 8'h01, DATA = 8'h01, DUTY = 64 → bit 0 high for exactly 128 of every 512 cycles; bits 7:1 low.
- DUTY = 0, then DUTY = 255 with MODE bit set → bit never high; then high 255×PRESCALE of every 256×PRESCALE cycles.
- WIDTH = 4, write DATA = 32'hFFFF_FFFF → `out_port` = 4'hF and a read returns 32'h0000_000F; write to address 6 leaves all registers unchanged.
- Assert `reset` in the same cycle as a DATA write mid-PWM → DATA = RESET_VALUE, PHASE reads 0 the next cycle, and the write is lost.
